tick_sched: RTL
===============

Name: tick_sched

Overview:
- Synchronous, programmable timebase controller that replaces ripple-clocked division with a single-clock tick-enable scheme.
- Sequences one divider: start/stop control, periodic or one-shot mode, and glitch-free reconfiguration of the division ratio through a valid/ready config port.
- Downstream logic runs on clk and qualifies its work with tick, so there is no derived clock.

Parameters:
- DIV_W, 16, width of the divide value and the internal counter.
- DEFAULT_DIV, 15, divide value loaded at reset; period = DEFAULT_DIV+1 cycles.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted this cycle.
- cfg_div  in  DIV_W  new divide value; tick period = cfg_div+1 cycles.
- cfg_oneshot  in  1  new mode: 1 = one tick then stop, 0 = periodic.
- start  in  1  begin counting (level sampled each cycle).
- stop  in  1  abort counting.
- tick  out  1  one-cycle enable at terminal count.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after a one-shot tick completes.
- count  out  DIV_W  current counter value.

Behaviour:
- Reset (sampled high at an edge) forces the following state:
  - state=IDLE, cnt=0, div_reg=DEFAULT_DIV, mode_reg=0.
  - Shadow register empty; cfg_ready=1, tick=0, busy=0, done=0, count=0.
  - Reset mid-run aborts immediately, discards any pending shadow config, and produces no tick or done.
- States: IDLE and RUN.
  - busy = (state==RUN), registered-state decode.
- Config handshake: a transfer occurs on any edge with cfg_valid && cfg_ready.
  - In IDLE: cfg_ready=1; accepted values write div_reg and mode_reg at that edge.
  - In RUN, shadow empty: cfg_ready=1; accepted values go to the shadow and set pending.
  - In RUN, shadow full: cfg_ready=0; the requester must hold cfg_valid.
  - Pending shadow commit: into div_reg/mode_reg at the terminal-count edge, and the counter reloads 0 with the new ratio. Alternatively it commits at the edge leaving RUN (stop or one-shot end). The shadow empties either way.
- IDLE -> RUN when start=1 and stop=0.
  - cnt loads 0.
  - Config accepted in the same edge is used for this run.
- Counting in RUN:
  - cnt increments each cycle.
  - When cnt==div_reg: tick=1 combinationally that cycle, and cnt reloads 0 at the next edge.
  - First tick appears div_reg+1 cycles after the start edge, then every div_reg+1 cycles.
  - div_reg=0: tick every RUN cycle.
- One-shot (mode_reg=1):
  - At the first terminal-count edge, RUN -> IDLE.
  - done=1 (registered) for exactly the following cycle; cnt=0.
- stop=1 in RUN: next edge -> IDLE, cnt=0, done stays 0.
  - If stop coincides with terminal count, that cycle's tick is still emitted.
  - stop overrides start when both are high; in IDLE, stop has no effect.
- start while in RUN is ignored; there is no restart.
- Start in the same cycle done is high is legal: new run begins at that edge.
- Arithmetic: unsigned compare of DIV_W bits; cnt never exceeds div_reg.
- Shadow commit of a value smaller than the current cnt cannot occur, because the commit happens only at reload.

Test Plan:
- Reset, then start for 1 cycle -> first tick 16 cycles after the start edge, then every 16; busy=1, count ramps 0..15.
- cfg_div=0, cfg_oneshot=0 in IDLE, then start -> tick every cycle while RUN.
- cfg_div=4, cfg_oneshot=1, start -> single tick at cycle 5, done pulse the next cycle; busy and tick then 0.
- RUN with div 9: accept cfg_div=2 mid-period -> next tick still at the 10-cycle boundary, subsequent ticks every 3 cycles.
  - A second cfg_valid before commit sees cfg_ready=0 until that boundary.
- RUN with div 3: stop asserted exactly at cnt==3 -> tick emitted that cycle, IDLE next cycle, done=0, count=0.
- Reset asserted mid-run with a pending shadow -> next cycle all outputs at reset values, div_reg=15, and the shadow value is never applied.

Source files
------------

// File: rtl/tick_sched.sv
// Programmable tick-enable timebase: one divider with start/stop, one-shot
// mode and a shadowed valid/ready config port committed at counter reload.
module tick_sched #(
    parameter int          DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] count
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             sh_mode_q, sh_mode_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;

    logic accept;
    logic tc;
    logic leave;

    assign busy      = (state_q == RUN);
    assign tc        = busy && (cnt_q == div_q);
    assign tick      = tc;
    assign cfg_ready = !busy || !pend_q;
    assign accept    = cfg_valid && cfg_ready;
    assign done      = done_q;
    assign count     = cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        mode_d    = mode_q;
        sh_div_d  = sh_div_q;
        sh_mode_d = sh_mode_q;
        pend_d    = pend_q;
        done_d    = 1'b0;
        leave     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    div_d  = cfg_div;
                    mode_d = cfg_oneshot;
                end
                if (start && !stop) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                leave = stop || (tc && mode_q);
                // Reload point: the only place the ratio may change, so a
                // config arriving on this very edge is applied directly.
                if (leave || tc) begin
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    if (pend_q) begin
                        div_d  = sh_div_q;
                        mode_d = sh_mode_q;
                    end else if (accept) begin
                        div_d  = cfg_div;
                        mode_d = cfg_oneshot;
                    end
                    if (leave) begin
                        state_d = IDLE;
                    end
                    done_d = tc && mode_q && !stop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (accept) begin
                        sh_div_d  = cfg_div;
                        sh_mode_d = cfg_oneshot;
                        pend_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_W'(DEFAULT_DIV);
            mode_q    <= 1'b0;
            sh_div_q  <= '0;
            sh_mode_q <= 1'b0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            sh_div_q  <= sh_div_d;
            sh_mode_q <= sh_mode_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
        end
    end

endmodule
